// File: rtl/fetch_flow_ctrl_if.sv
// Purpose: bundles fetch-sequencing requests (ID/CP0/hazard side) and the
// Latency: wires only, no state.
// Backpressure: none; the controller answers every cycle via stall/zero conditions.
// Ports: master = pipeline side (drives requests, consumes selects/conditions),
//        slave  = fetch_flow_ctrl (consumes requests, drives selects/conditions).
interface fetch_flow_ctrl_if;
  logic        intr_req;
  logic        intr_en;
  logic        eret;
  logic        md_start;
  logic        load_use;
  logic        jr;
  logic        branch_taken;
  logic        jump;
  logic [2:0]  mux_pc;
  logic [1:0]  cond_if;
  logic [1:0]  cond_id;
  logic [1:0]  cond_ex;
  logic        epc_we;
  logic        intr_ack;
  logic        md_busy;
  logic        in_handler;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output intr_req, intr_en, eret, md_start, load_use, jr, branch_taken, jump,
    input  mux_pc, cond_if, cond_id, cond_ex, epc_we, intr_ack, md_busy,
           in_handler, stall_cnt, flush_cnt
  );

  modport slave (
    input  intr_req, intr_en, eret, md_start, load_use, jr, branch_taken, jump,
    output mux_pc, cond_if, cond_id, cond_ex, epc_we, intr_ack, md_busy,
           in_handler, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_flow_ctrl.sv
// Purpose: picks next-PC source and FLOW/STALL/ZERO per fetch-side pipeline register.
// Latency: combinational decision; redirects land on the next rising edge.
// Backpressure: mult/div holds IF/ID stalled for MD_CYCLES cycles; load_use stalls while high.
// Ports: clk, rst (sync, active-high), ffc (slave modport of fetch_flow_ctrl_if).
// Optional: define FETCH_PERF_CNT_EN to build stall_cnt/flush_cnt counters;
//           otherwise both read 0 and no counter flops exist.
module fetch_flow_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input logic               clk,
  input logic               rst,
  fetch_flow_ctrl_if.slave  ffc
);

  localparam logic [1:0] FLOW  = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] ZERO  = 2'b10;

  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_RS     = 3'd2;
  localparam logic [2:0] PC_INTR   = 3'd3;
  localparam logic [2:0] PC_EPC    = 3'd4;
  localparam logic [2:0] PC_JUMP   = 3'd5;
  localparam logic [2:0] PC_SEQ    = 3'd6;

  // The md_start cycle itself is the first stall cycle, so the wait
  // state only needs to cover the remaining MD_CYCLES-1 cycles.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  typedef enum logic {RUN, MDWAIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       in_handler, in_handler_nxt;

  logic [2:0] mux_pc;
  logic [1:0] cond_if, cond_id, cond_ex;
  logic       epc_we, intr_ack, md_busy;
  logic       intr_take;

  assign intr_take = ffc.intr_req & ffc.intr_en & ~in_handler;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= 8'd0;
      in_handler <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      in_handler <= in_handler_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    in_handler_nxt = in_handler;
    mux_pc         = PC_SEQ;
    cond_if        = FLOW;
    cond_id        = FLOW;
    cond_ex        = FLOW;
    epc_we         = 1'b0;
    intr_ack       = 1'b0;
    md_busy        = 1'b0;

    case (state)
      RUN: begin
        if (intr_take) begin
          // Younger instruction in ID/EX is squashed; EPC captures the resume point.
          mux_pc         = PC_INTR;
          cond_id        = ZERO;
          cond_ex        = ZERO;
          epc_we         = 1'b1;
          intr_ack       = 1'b1;
          in_handler_nxt = 1'b1;
        end else if (ffc.eret) begin
          mux_pc         = PC_EPC;
          cond_id        = ZERO;
          in_handler_nxt = 1'b0;
        end else if (ffc.md_start) begin
          cond_if   = STALL;
          cond_id   = STALL;
          cond_ex   = ZERO;
          md_busy   = 1'b1;
          cnt_nxt   = MD_LOAD;
          state_nxt = MDWAIT;
        end else if (ffc.load_use) begin
          // Any redirect in ID waits until the hazard clears.
          cond_if = STALL;
          cond_id = STALL;
          cond_ex = ZERO;
        end else if (ffc.jr) begin
          mux_pc  = PC_RS;
          cond_id = ZERO;
        end else if (ffc.branch_taken) begin
          mux_pc  = PC_BRANCH;
          cond_id = ZERO;
        end else if (ffc.jump) begin
          mux_pc  = PC_JUMP;
          cond_id = ZERO;
        end
      end
      MDWAIT: begin
        md_busy = 1'b1;
        cond_if = STALL;
        cond_id = STALL;
        cond_ex = ZERO;
        cnt_nxt = cnt - 8'd1;
        if (cnt_nxt == 8'd0) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign ffc.mux_pc     = mux_pc;
  assign ffc.cond_if    = cond_if;
  assign ffc.cond_id    = cond_id;
  assign ffc.cond_ex    = cond_ex;
  assign ffc.epc_we     = epc_we;
  assign ffc.intr_ack   = intr_ack;
  assign ffc.md_busy    = md_busy;
  assign ffc.in_handler = in_handler;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (cond_if == STALL) stall_cnt <= stall_cnt + 32'd1;
      if (cond_id == ZERO)  flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign ffc.stall_cnt = stall_cnt;
  assign ffc.flush_cnt = flush_cnt;
`else
  assign ffc.stall_cnt = 32'd0;
  assign ffc.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Purpose: directed check of fetch_flow_ctrl priorities, mult/div wait and interrupt state.
// Latency: inputs applied 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: n/a (bench drives every cycle).
module tb_fetch_flow_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_flow_ctrl_if ffc_if ();

  fetch_flow_ctrl #(.MD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .ffc (ffc_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    ffc_if.intr_req     = 1'b0;
    ffc_if.intr_en      = 1'b0;
    ffc_if.eret         = 1'b0;
    ffc_if.md_start     = 1'b0;
    ffc_if.load_use     = 1'b0;
    ffc_if.jr           = 1'b0;
    ffc_if.branch_taken = 1'b0;
    ffc_if.jump         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks mux_pc and the three conditions in one call.
  task automatic chk_flow(input string tag, input logic [2:0] pc,
                          input logic [1:0] ci, input logic [1:0] cd, input logic [1:0] ce);
    #1;
    chk({tag, ".mux_pc"},  32'(ffc_if.mux_pc),  32'(pc));
    chk({tag, ".cond_if"}, 32'(ffc_if.cond_if), 32'(ci));
    chk({tag, ".cond_id"}, 32'(ffc_if.cond_id), 32'(cd));
    chk({tag, ".cond_ex"}, 32'(ffc_if.cond_ex), 32'(ce));
  endtask

  logic [31:0] exp_stall;

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 2; i++) begin
      chk_flow("idle", 3'd6, 2'b00, 2'b00, 2'b00);
      chk("idle.md_busy",  32'(ffc_if.md_busy),    32'd0);
      chk("idle.in_hand",  32'(ffc_if.in_handler), 32'd0);
      chk("idle.epc_we",   32'(ffc_if.epc_we),     32'd0);
      chk("idle.ack",      32'(ffc_if.intr_ack),   32'd0);
      chk("idle.stallcnt", ffc_if.stall_cnt,       32'd0);
      chk("idle.flushcnt", ffc_if.flush_cnt,       32'd0);
      step();
    end

    // Taken branch, then sequential
    ffc_if.branch_taken = 1'b1;
    chk_flow("br", 3'd1, 2'b00, 2'b10, 2'b00);
    step();
    idle();
    chk_flow("br_after", 3'd6, 2'b00, 2'b00, 2'b00);
    step();

    // Mult/div: 4 busy cycles, interrupt pending during the wait
    ffc_if.md_start = 1'b1;
    #1;
    chk("md0.busy", 32'(ffc_if.md_busy), 32'd1);
    chk_flow("md0", 3'd6, 2'b01, 2'b01, 2'b10);
    step();
    idle();
    ffc_if.intr_req = 1'b1;
    ffc_if.intr_en  = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("mdw.busy",    32'(ffc_if.md_busy),  32'd1);
      chk("mdw.cond_if", 32'(ffc_if.cond_if),  32'd1);
      chk("mdw.cond_ex", 32'(ffc_if.cond_ex),  32'd2);
      chk("mdw.ack",     32'(ffc_if.intr_ack), 32'd0);
      step();
    end
    chk_flow("md_intr", 3'd3, 2'b00, 2'b10, 2'b10);
    chk("md_intr.busy", 32'(ffc_if.md_busy),  32'd0);
    chk("md_intr.ack",  32'(ffc_if.intr_ack), 32'd1);
    chk("md_intr.epc",  32'(ffc_if.epc_we),   32'd1);
    step();
    chk("md_intr.inh",  32'(ffc_if.in_handler), 32'd1);
    chk("md_intr.held", 32'(ffc_if.intr_ack),   32'd0);
    // Leave handler
    idle();
    ffc_if.eret = 1'b1;
    chk_flow("eret1", 3'd4, 2'b00, 2'b10, 2'b00);
    step();
    idle();
    #1;
    chk("eret1.inh", 32'(ffc_if.in_handler), 32'd0);

    // Interrupt coinciding with taken branch wins
    ffc_if.intr_req     = 1'b1;
    ffc_if.intr_en      = 1'b1;
    ffc_if.branch_taken = 1'b1;
    chk_flow("ibr", 3'd3, 2'b00, 2'b10, 2'b10);
    chk("ibr.epc", 32'(ffc_if.epc_we),   32'd1);
    chk("ibr.ack", 32'(ffc_if.intr_ack), 32'd1);
    step();
    ffc_if.branch_taken = 1'b0;
    #1;
    chk("ibr.inh",  32'(ffc_if.in_handler), 32'd1);
    chk("ibr.held", 32'(ffc_if.intr_ack),   32'd0);
    chk("ibr.pc",   32'(ffc_if.mux_pc),     32'd6);
    step();
    ffc_if.intr_req = 1'b0;
    ffc_if.eret     = 1'b1;
    chk_flow("eret2", 3'd4, 2'b00, 2'b10, 2'b00);
    step();
    #1;
    chk("eret2.inh", 32'(ffc_if.in_handler), 32'd0);
    // eret without a handler still redirects
    chk_flow("eret3", 3'd4, 2'b00, 2'b10, 2'b00);
    step();
    idle();
    #1;
    chk("eret3.inh", 32'(ffc_if.in_handler), 32'd0);

    // Interrupt masked by intr_en=0
    ffc_if.intr_req = 1'b1;
    ffc_if.jr       = 1'b1;
    ffc_if.branch_taken = 1'b1;
    chk_flow("jr_pri", 3'd2, 2'b00, 2'b10, 2'b00);
    chk("mask.ack", 32'(ffc_if.intr_ack), 32'd0);
    step();
    idle();

    // load_use held 3 cycles with a pending jump
    ffc_if.load_use = 1'b1;
    ffc_if.jump     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_flow("lu", 3'd6, 2'b01, 2'b01, 2'b10);
      step();
    end
    ffc_if.load_use = 1'b0;
    chk_flow("lu_jump", 3'd5, 2'b00, 2'b10, 2'b00);
    step();
    idle();

    // Reset in 2nd MDWAIT cycle aborts the wait
    ffc_if.md_start = 1'b1;
    step();
    idle();
    step();
    rst = 1'b1;
    #1;
    chk("rstmd.busy_pre", 32'(ffc_if.md_busy), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("rstmd.busy", 32'(ffc_if.md_busy), 32'd0);
    chk_flow("rstmd", 3'd6, 2'b00, 2'b00, 2'b00);
    chk("rstmd.stallcnt", ffc_if.stall_cnt, 32'd0);
    chk("rstmd.flushcnt", ffc_if.flush_cnt, 32'd0);

    // Perf counter: md_start (4 stall cycles) + one load_use cycle
    ffc_if.md_start = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    ffc_if.load_use = 1'b1;
    step();
    idle();
    #1;
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    chk("perf.stallcnt", ffc_if.stall_cnt, exp_stall);
    chk("perf.flushcnt", ffc_if.flush_cnt, 32'd0);
    chk("perf.busy", 32'(ffc_if.md_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_flow_ctrl.md
Name: fetch_flow_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage and the two pipeline registers behind it.
- Each cycle it decides the next-PC source select (mux_pc) and one flow condition per stage (FLOW / STALL / ZERO).
- Inputs it arbitrates: redirects (branch, jump, jr, interrupt, eret), load-use hazards and multi-cycle mult/div occupancy.
- Keeps the interrupt-in-service state and the mult/div wait countdown.

Parameters:
- MD_CYCLES, 32, number of cycles the mult/div unit holds the pipeline after md_start (legal range 2..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- intr_req  in  1  level interrupt request from CP0.
- intr_en  in  1  CP0 global interrupt enable.
- eret  in  1  ERET decoded in ID.
- md_start  in  1  mult/div instruction issued in ID.
- load_use  in  1  hazard unit: ID consumer of an EX load.
- jr  in  1  JR/JALR decoded in ID.
- branch_taken  in  1  taken conditional branch in ID.
- jump  in  1  J/JAL decoded in ID.
- mux_pc  out  3  next-PC select: 1 branch target, 2 Rs, 3 intr addr, 4 EPC, 5 jump target, 6 PC+4.
- cond_if  out  2  condition for the PC/IR fetch register.
- cond_id  out  2  condition for the IF/ID register.
- cond_ex  out  2  condition for the ID/EX register.
- epc_we  out  1  CP0 EPC write strobe.
- intr_ack  out  1  interrupt accepted pulse.
- md_busy  out  1  high while waiting on mult/div.
- in_handler  out  1  interrupt service in progress.
- stall_cnt  out  32  perf counter (optional feature).
- flush_cnt  out  32  perf counter (optional feature).

Behaviour:
- Condition encoding: FLOW=2'b00, STALL=2'b01, ZERO=2'b10. 2'b11 is never driven.
- Outputs are combinational from registered state and current inputs. Only the state, the counter and in_handler are registered.
- State machine: RUN, MDWAIT.
- Reset (synchronous): state=RUN, counter=0, in_handler=0. Outputs then read mux_pc=6, all cond=FLOW, epc_we=0, intr_ack=0, md_busy=0.
- Reset mid-MDWAIT aborts the wait immediately.
- RUN priority, highest first (exactly one action per cycle):
  1. Interrupt (intr_req & intr_en & ~in_handler): mux_pc=3; cond_if=FLOW; cond_id=ZERO; cond_ex=ZERO; epc_we=1; intr_ack=1; in_handler<=1.
  2. eret: mux_pc=4; cond_if=FLOW; cond_id=ZERO; in_handler<=0.
  3. md_start: cond_if=STALL; cond_id=STALL; cond_ex=ZERO; counter<=MD_CYCLES-1; state<=MDWAIT.
  4. load_use: cond_if=STALL; cond_id=STALL; cond_ex=ZERO; mux_pc=6. Held for as long as load_use is high.
  5. jr: mux_pc=2; cond_id=ZERO.
  6. branch_taken: mux_pc=1; cond_id=ZERO.
  7. jump: mux_pc=5; cond_id=ZERO.
  8. None of the above: mux_pc=6, all FLOW.
  - Any cond not named in an item is FLOW.
- MDWAIT:
  - md_busy=1; cond_if=STALL; cond_id=STALL; cond_ex=ZERO; counter decrements each cycle.
  - When the counter reaches 0: state<=RUN.
  - The cycle after MDWAIT exits is evaluated as RUN.
  - Interrupts are not accepted in MDWAIT. intr_req stays pending (level) and is taken on the first RUN cycle.
- Latency: redirect takes effect at the next rising edge (0 added cycles). md_start stalls exactly MD_CYCLES cycles.
- Simultaneous events resolve by the priority above. An interrupt that coincides with a taken branch wins, and the branch is squashed via cond_id=ZERO.
- eret while in_handler=0 still redirects to the EPC; in_handler stays 0.
- A second intr_req while in_handler=1 is ignored until eret.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with cond_if=STALL.
  - flush_cnt increments on every cycle with cond_id=ZERO.
  - Both are cleared by rst and wrap modulo 2^32.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built. Ports remain present.

Test Plan:
- rst=1 for 2 cycles, then idle inputs -> mux_pc=6, all cond=00, md_busy=0, in_handler=0 every cycle.
- branch_taken=1 for one cycle -> that cycle mux_pc=1, cond_id=10, cond_if=00; next cycle mux_pc=6.
- md_start=1 (MD_CYCLES=4) -> md_busy=1 for exactly 4 cycles with cond_if=01, cond_ex=10; then RUN. intr_req raised during the wait -> intr_ack=1 on the first RUN cycle with mux_pc=3.
- intr_req=1, intr_en=1, branch_taken=1 together -> mux_pc=3, epc_we=1, intr_ack=1, cond_id=10, in_handler=1. Held intr_req gives no second ack. eret -> mux_pc=4, in_handler=0.
- load_use=1 for 3 cycles with jump=1 -> 3 cycles of cond_if=01 and cond_ex=10 with mux_pc=6; jump takes effect (mux_pc=5) on the cycle load_use drops.
- rst asserted in the 2nd cycle of MDWAIT -> next cycle md_busy=0, state RUN. With FETCH_PERF_CNT_EN, stall_cnt=0 after reset and equals 5 after one md_start followed by one load_use cycle (MD_CYCLES=4).
